// File: rtl/bscac7_lane_scheduler_if.sv
// bscac7_lane_scheduler_if: handshake and TSV bus between the 7-lane BSCAC scheduler and its environment.
//   in_valid_i/in_ready_o/in_data_i : upstream 7-bit word push (bit i -> lane i)
//   tx_en_i, flush_i                : transmit-slot strobe, synchronous FIFO clear
//   cand_bits_o/free_mask_i         : candidate bits out, lanes 1..6 free mask back (bit j-1 -> lane j)
//   tsv_state_o, tx_fire_o, pop_mask_o, starve_o, fill_min_o : TSV drive and status
interface bscac7_lane_scheduler_if #(
    parameter int DEPTH = 8
);
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic [6:0]                   in_data_i;
    logic                         tx_en_i;
    logic                         flush_i;
    logic [6:0]                   cand_bits_o;
    logic [5:0]                   free_mask_i;
    logic [6:0]                   tsv_state_o;
    logic                         tx_fire_o;
    logic [6:0]                   pop_mask_o;
    logic [5:0]                   starve_o;
    logic [$clog2(DEPTH+1)-1:0]   fill_min_o;
    modport master (
        output in_valid_i, in_data_i, tx_en_i, flush_i, free_mask_i,
        input  in_ready_o, cand_bits_o, tsv_state_o, tx_fire_o, pop_mask_o, starve_o, fill_min_o
    );
    modport slave (
        input  in_valid_i, in_data_i, tx_en_i, flush_i, free_mask_i,
        output in_ready_o, cand_bits_o, tsv_state_o, tx_fire_o, pop_mask_o, starve_o, fill_min_o
    );
endinterface

// File: rtl/bscac7_lane_scheduler.sv
// bscac7_lane_scheduler: per-lane FIFOs feeding the registered 7-TSV state, popping lanes allowed by the free mask.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bscac7_lane_scheduler_if (push handshake, transmit control, TSV drive, status)
module bscac7_lane_scheduler #(
    parameter int DEPTH     = 8,
    parameter int MAX_STALL = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    bscac7_lane_scheduler_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(MAX_STALL+1);

    logic [DEPTH-1:0] mem_q [7];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q [7];
    logic [AW-1:0]    rd_ptr_d [7];
    logic [CW-1:0]    cnt_q [7];
    logic [CW-1:0]    cnt_d [7];
    logic [SW-1:0]    stall_q [6];
    logic [SW-1:0]    stall_d [6];
    logic [6:0]       tsv_q, tsv_d, pop_mask_q, pop_mask_d, head, nonempty, pop;
    logic [5:0]       starve_q, starve_d;
    logic             tx_fire_q, full, push, tx;
    logic [CW-1:0]    min_c;

    always_comb begin
        full = 1'b0;
        for (int i = 0; i < 7; i++) begin
            head[i]     = mem_q[i][rd_ptr_q[i]];
            nonempty[i] = cnt_q[i] != '0;
            full        = full | (cnt_q[i] == CW'(DEPTH));
        end
        // all lanes share one write pointer because every push writes all seven lanes
        push       = bus.in_valid_i & ~full & ~bus.flush_i;
        tx         = bus.tx_en_i & nonempty[0] & ~bus.flush_i;
        pop        = {{6{tx}} & bus.free_mask_i & nonempty[6:1], tx};
        wr_ptr_d   = bus.flush_i ? '0 : wr_ptr_q + AW'(push);
        pop_mask_d = tx ? pop : pop_mask_q;
        min_c      = cnt_q[0];
        for (int i = 0; i < 7; i++) begin
            rd_ptr_d[i] = bus.flush_i ? '0 : rd_ptr_q[i] + AW'(pop[i]);
            cnt_d[i]    = bus.flush_i ? '0 : cnt_q[i] + CW'(push) - CW'(pop[i]);
            tsv_d[i]    = pop[i] ? head[i] : tsv_q[i];
            min_c       = (cnt_q[i] < min_c) ? cnt_q[i] : min_c;
        end
        // stall counters survive flush; only a pop of that lane or rst clears them
        for (int i = 0; i < 6; i++) begin
            stall_d[i]  = pop[i+1] ? '0 :
                          (tx & nonempty[i+1] & (stall_q[i] != SW'(MAX_STALL))) ? stall_q[i] + SW'(1) :
                          stall_q[i];
            starve_d[i] = starve_q[i] | (stall_d[i] == SW'(MAX_STALL));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            tsv_q      <= '0;
            pop_mask_q <= '0;
            starve_q   <= '0;
            tx_fire_q  <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            for (int i = 0; i < 6; i++) stall_q[i] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            tsv_q      <= tsv_d;
            pop_mask_q <= pop_mask_d;
            starve_q   <= starve_d;
            tx_fire_q  <= tx;
            for (int i = 0; i < 7; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            for (int i = 0; i < 6; i++) stall_q[i] <= stall_d[i];
        end
    end

    // storage needs no reset: counts gate every read
    always_ff @(posedge clk) begin
        if (push) for (int i = 0; i < 7; i++) mem_q[i][wr_ptr_q] <= bus.in_data_i[i];
    end

    assign bus.in_ready_o  = ~full & ~bus.flush_i;
    assign bus.cand_bits_o = (nonempty & head) | (~nonempty & tsv_q);
    assign bus.tsv_state_o = tsv_q;
    assign bus.tx_fire_o   = tx_fire_q;
    assign bus.pop_mask_o  = pop_mask_q;
    assign bus.starve_o    = starve_q;
    assign bus.fill_min_o  = min_c;
endmodule

// File: tb/tb_bscac7_lane_scheduler.sv
// tb_bscac7_lane_scheduler: directed and random stimulus against a per-lane queue scoreboard.
module tb_bscac7_lane_scheduler;
    localparam int DEPTH     = 8;
    localparam int MAX_STALL = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bscac7_lane_scheduler_if #(.DEPTH(DEPTH)) bus ();
    bscac7_lane_scheduler #(.DEPTH(DEPTH), .MAX_STALL(MAX_STALL)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int         checks = 0;
    int         errors = 0;
    bit         mq [7][$];
    logic [6:0] m_tsv = '0;
    logic [6:0] m_pop = '0;
    logic       m_fire = 1'b0;
    logic [5:0] m_starve = '0;
    int         m_stall [6];
    logic [6:0] saved_tsv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int mmin();
        int m = mq[0].size();
        for (int i = 1; i < 7; i++) if (mq[i].size() < m) m = mq[i].size();
        return m;
    endfunction

    task automatic step(input logic v, input logic [6:0] d, input logic te, input logic fl,
                        input logic [5:0] fm, input logic r);
        bit full, push, tx;
        logic [6:0] pop, cand;
        rst = r;
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.tx_en_i     = te;
        bus.flush_i     = fl;
        bus.free_mask_i = fm;
        #1;
        full = 0;
        for (int i = 0; i < 7; i++) if (mq[i].size() >= DEPTH) full = 1;
        for (int i = 0; i < 7; i++) cand[i] = (mq[i].size() > 0) ? mq[i][0] : m_tsv[i];
        chk("in_ready", 32'(bus.in_ready_o), 32'(!full && !fl));
        chk("cand_bits", 32'(bus.cand_bits_o), 32'(cand));
        if (r) begin
            for (int i = 0; i < 7; i++) mq[i].delete();
            for (int i = 0; i < 6; i++) m_stall[i] = 0;
            m_tsv = '0; m_pop = '0; m_fire = 1'b0; m_starve = '0;
        end else begin
            push = v && !full && !fl;
            tx   = te && mq[0].size() > 0 && !fl;
            pop  = '0;
            if (tx) begin
                pop[0] = 1'b1;
                for (int j = 1; j < 7; j++) if (fm[j-1] && mq[j].size() > 0) pop[j] = 1'b1;
                for (int j = 1; j < 7; j++) begin
                    if (pop[j]) m_stall[j-1] = 0;
                    else if (mq[j].size() > 0 && m_stall[j-1] < MAX_STALL) m_stall[j-1]++;
                    if (m_stall[j-1] == MAX_STALL) m_starve[j-1] = 1'b1;
                end
                for (int i = 0; i < 7; i++) if (pop[i]) m_tsv[i] = mq[i].pop_front();
                m_pop = pop;
            end
            m_fire = tx;
            if (fl) for (int i = 0; i < 7; i++) mq[i].delete();
            if (push) for (int i = 0; i < 7; i++) mq[i].push_back(d[i]);
        end
        @(posedge clk);
        #1;
        chk("tsv_state", 32'(bus.tsv_state_o), 32'(m_tsv));
        chk("tx_fire", 32'(bus.tx_fire_o), 32'(m_fire));
        chk("pop_mask", 32'(bus.pop_mask_o), 32'(m_pop));
        chk("starve", 32'(bus.starve_o), 32'(m_starve));
        chk("fill_min", 32'(bus.fill_min_o), 32'(mmin()));
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.tx_en_i     = 1'b0;
        bus.flush_i     = 1'b0;
        bus.free_mask_i = '0;
        for (int i = 0; i < 6; i++) m_stall[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tsv", 32'(bus.tsv_state_o), 32'h0);
        chk("rst_fire", 32'(bus.tx_fire_o), 32'h0);
        chk("rst_pop", 32'(bus.pop_mask_o), 32'h0);
        chk("rst_starve", 32'(bus.starve_o), 32'h0);
        chk("rst_fill", 32'(bus.fill_min_o), 32'h0);
        chk("rst_ready", 32'(bus.in_ready_o), 32'h1);

        // single word through all lanes, two cycles to tsv_state
        step(1, 7'h7F, 1, 0, 6'h3F, 0);
        chk("t1_tsv_early", 32'(bus.tsv_state_o), 32'h0);
        step(0, 7'h00, 1, 0, 6'h3F, 0);
        chk("t1_tsv", 32'(bus.tsv_state_o), 32'h7F);
        chk("t1_fire", 32'(bus.tx_fire_o), 32'h1);
        chk("t1_pop", 32'(bus.pop_mask_o), 32'h7F);
        step(0, 7'h00, 0, 0, 6'h3F, 0);
        chk("t1_fire_off", 32'(bus.tx_fire_o), 32'h0);

        // fill to DEPTH, refused push, one transmit reopens
        for (int k = 0; k < DEPTH; k++) step(1, 7'($urandom), 0, 0, 6'h3F, 0);
        chk("t2_ready", 32'(bus.in_ready_o), 32'h0);
        chk("t2_fill", 32'(bus.fill_min_o), 32'(DEPTH));
        step(1, 7'h55, 0, 0, 6'h3F, 0);
        chk("t2_held", 32'(bus.fill_min_o), 32'(DEPTH));
        step(0, 7'h00, 1, 0, 6'h3F, 0);
        chk("t2_ready_back", 32'(bus.in_ready_o), 32'h1);

        // only lane 2 free: lanes 0 and 2 pop
        step(1, 7'($urandom), 0, 0, 6'h3F, 0);
        for (int k = 0; k < 3; k++) step(0, 7'h00, 1, 0, 6'b000010, 0);
        chk("t3_pop", 32'(bus.pop_mask_o), 32'b0000101);
        chk("t3_fill", 32'(bus.fill_min_o), 32'(DEPTH - 3));

        // lane 3 blocked for 15 transmits (flush in between keeps its counter)
        step(0, 7'h00, 0, 0, 6'h3F, 1);
        for (int k = 0; k < DEPTH; k++) step(1, 7'($urandom), 0, 0, 6'h3B, 0);
        for (int k = 0; k < DEPTH; k++) step(0, 7'h00, 1, 0, 6'h3B, 0);
        step(0, 7'h00, 0, 1, 6'h3B, 0);
        for (int k = 0; k < 7; k++) step(1, 7'($urandom), 0, 0, 6'h3B, 0);
        for (int k = 0; k < 6; k++) step(0, 7'h00, 1, 0, 6'h3B, 0);
        chk("t4_no_starve", 32'(bus.starve_o), 32'h0);
        step(0, 7'h00, 1, 0, 6'h3B, 0);
        chk("t4_starve", 32'(bus.starve_o), 32'b000100);
        step(1, 7'($urandom), 0, 0, 6'h3F, 0);
        step(0, 7'h00, 1, 0, 6'h3F, 0);
        chk("t4_pop3", 32'(bus.pop_mask_o), 32'h7F);
        chk("t4_sticky", 32'(bus.starve_o), 32'b000100);

        // flush with queued words and a same-cycle push
        step(0, 7'h00, 0, 1, 6'h3F, 0);
        for (int k = 0; k < 5; k++) step(1, 7'($urandom), 0, 0, 6'h3F, 0);
        saved_tsv = m_tsv;
        step(1, 7'h7F, 1, 1, 6'h3F, 0);
        chk("t5_fill", 32'(bus.fill_min_o), 32'h0);
        chk("t5_tsv", 32'(bus.tsv_state_o), 32'(saved_tsv));
        step(0, 7'h00, 0, 0, 6'h3F, 0);
        chk("t5_dropped", 32'(bus.fill_min_o), 32'h0);

        // reset in the middle of a transmit burst
        for (int k = 0; k < 4; k++) step(1, 7'($urandom), 0, 0, 6'h3F, 0);
        step(0, 7'h00, 1, 0, 6'h3F, 0);
        step(1, 7'h7F, 1, 0, 6'h3F, 1);
        chk("t6_tsv", 32'(bus.tsv_state_o), 32'h0);
        chk("t6_fire", 32'(bus.tx_fire_o), 32'h0);
        chk("t6_pop", 32'(bus.pop_mask_o), 32'h0);
        chk("t6_starve", 32'(bus.starve_o), 32'h0);
        chk("t6_fill", 32'(bus.fill_min_o), 32'h0);

        // random traffic against the scoreboard
        for (int k = 0; k < 300; k++)
            step(1'($urandom_range(0, 3) != 0), 7'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0), 6'($urandom), 1'($urandom_range(0, 99) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
